// File: rtl/cpu_bus_pkg.sv
// Shared types and constants for the CPU bus responder and its scratchpad RAM.
package cpu_bus_pkg;

    localparam int BUS_ADDR_W = 27;
    localparam int BUS_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_e;

    // Offset of the top word of a window that is addr_bits wide (all ones).
    function automatic logic [BUS_ADDR_W-1:0] status_offset(input int unsigned addr_bits);
        status_offset = (BUS_ADDR_W'(1) << addr_bits) - BUS_ADDR_W'(1);
    endfunction

endpackage

// File: rtl/responder_ram.sv
// Single-port scratchpad RAM: synchronous write, registered read-first output.
module responder_ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rd_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= d;
        end
        rd_q <= mem[addr];
    end

    assign q = rd_q;

endmodule

// File: rtl/cpu_bus_responder.sv
// Memory-mapped scratchpad window on the CPU request bus with programmable wait states.
// Optional access counters and status word when CPU_BUS_RESPONDER_STATS_EN is defined.
module cpu_bus_responder
    import cpu_bus_pkg::*;
#(
    parameter logic [BUS_ADDR_W-1:0] BASE_ADDR   = 27'h0400000,
    parameter int                    ADDR_BITS   = 8,
    parameter int                    WAIT_STATES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [BUS_ADDR_W-1:0] address,
    input  logic [BUS_DATA_W-1:0] data,
    input  logic                  we,
    input  logic                  start,
    output logic                  busy,
    output logic [BUS_DATA_W-1:0] q,
    output logic                  sel
);

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  armed_q, armed_d;
    logic [ADDR_BITS-1:0]  addr_q, addr_d;
    logic [BUS_DATA_W-1:0] data_q, data_d;
    logic                  we_q, we_d;
    logic [BUS_DATA_W-1:0] q_q, q_d;

    logic                  accept;
    logic                  ram_we;
    logic [BUS_DATA_W-1:0] ram_q;
    logic [BUS_DATA_W-1:0] rd_data;

    assign sel    = (address[BUS_ADDR_W-1:ADDR_BITS] == BASE_ADDR[BUS_ADDR_W-1:ADDR_BITS]);
    assign accept = (state_q == IDLE) && start && sel && armed_q;
    assign busy   = (state_q == WAIT) || (state_q == ACCESS);

    // Read data is driven straight from the RAM/status path during DONE, then held in q_q.
    assign q = ((state_q == DONE) && !we_q) ? rd_data : q_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        armed_d = armed_q;
        addr_d  = addr_q;
        data_d  = data_q;
        we_d    = we_q;
        q_d     = q_q;

        // Level-sensitive start: a new request needs start seen low at least once.
        if (!start) begin
            armed_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = WAIT;
                    cnt_d   = WAIT_INIT;
                    armed_d = 1'b0;
                    addr_d  = address[ADDR_BITS-1:0];
                    data_d  = data;
                    we_d    = we;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ACCESS;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ACCESS: begin
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
                if (!we_q) begin
                    q_d = rd_data;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            armed_q <= 1'b1;
            addr_q  <= '0;
            data_q  <= '0;
            we_q    <= 1'b0;
            q_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            we_q    <= we_d;
            q_q     <= q_d;
        end
    end

`ifdef CPU_BUS_RESPONDER_STATS_EN
    localparam logic [ADDR_BITS-1:0] STATUS_WORD = ADDR_BITS'(status_offset(ADDR_BITS));

    logic [15:0]           wr_cnt_q;
    logic [15:0]           rd_cnt_q;
    logic [BUS_DATA_W-1:0] status_q;
    logic                  status_hit;

    assign status_hit = (addr_q == STATUS_WORD);
    assign ram_we     = (state_q == ACCESS) && we_q && !reset && !status_hit;
    assign rd_data    = status_hit ? status_q : ram_q;

    // Status is snapshotted before this access bumps the counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_cnt_q <= 16'd0;
            rd_cnt_q <= 16'd0;
            status_q <= '0;
        end else if (state_q == ACCESS) begin
            status_q <= {wr_cnt_q, rd_cnt_q};
            if (we_q) begin
                if (status_hit) begin
                    wr_cnt_q <= 16'd0;
                    rd_cnt_q <= 16'd0;
                end else if (wr_cnt_q != 16'hFFFF) begin
                    wr_cnt_q <= wr_cnt_q + 16'd1;
                end
            end else if (rd_cnt_q != 16'hFFFF) begin
                rd_cnt_q <= rd_cnt_q + 16'd1;
            end
        end
    end
`else
    assign ram_we  = (state_q == ACCESS) && we_q && !reset;
    assign rd_data = ram_q;
`endif

    responder_ram #(
        .ADDR_W (ADDR_BITS),
        .DATA_W (BUS_DATA_W)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .addr (addr_q),
        .d    (data_q),
        .q    (ram_q)
    );

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Scoreboard bench for cpu_bus_responder: randomized and directed requests against a word-level model.
// Model follows CPU_BUS_RESPONDER_STATS_EN when the bench is built with that macro.
module tb_cpu_bus_responder;

    localparam logic [26:0] BASE = 27'h0400000;
    localparam int          AB   = 8;
    localparam int          WS   = 2;
    localparam int          TOP  = (1 << AB) - 1;

    logic        clk = 1'b0;
    logic        reset;
    logic [26:0] address;
    logic [31:0] data;
    logic        we;
    logic        start;
    logic        busy;
    logic [31:0] q;
    logic        sel;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cpu_bus_responder #(
        .BASE_ADDR   (BASE),
        .ADDR_BITS   (AB),
        .WAIT_STATES (WS)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .address (address),
        .data    (data),
        .we      (we),
        .start   (start),
        .busy    (busy),
        .q       (q),
        .sel     (sel)
    );

    typedef struct {
        logic [31:0] q;
        int          len;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model_mem [int];
    logic [31:0] model_q = '0;
    logic [15:0] m_wr = '0;
    logic [15:0] m_rd = '0;
    int          push_cnt = 0;
    int          rise_cnt = 0;
    bit          mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: a word-addressed memory plus the value q shows once a request completes.
    function automatic logic [31:0] predict(input int off, input logic w, input logic [31:0] d);
        logic [31:0] r;
        r = model_q;
`ifdef CPU_BUS_RESPONDER_STATS_EN
        if (off == TOP) begin
            if (w) begin
                m_wr = '0;
                m_rd = '0;
            end else begin
                r = {m_wr, m_rd};
                if (m_rd != 16'hFFFF) m_rd = m_rd + 16'd1;
            end
            model_q = r;
            return r;
        end
        if (w) begin
            if (m_wr != 16'hFFFF) m_wr = m_wr + 16'd1;
        end else if (m_rd != 16'hFFFF) begin
            m_rd = m_rd + 16'd1;
        end
`endif
        if (w) model_mem[off] = d;
        else   r = model_mem[off];
        model_q = r;
        return r;
    endfunction

    // Monitor: every completion (busy falling) is matched against the scoreboard head.
    initial begin
        logic  busy_prev;
        int    blen;
        exp_t  e;
        logic [31:0] hold;
        busy_prev = 1'b0;
        blen = 0;
        hold = '0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (busy === 1'b1) begin
                    if (!busy_prev) begin
                        rise_cnt++;
                        checks++;
                        if (rise_cnt > push_cnt) begin
                            errors++;
                            $display("FAIL busy_rise: got %0d starts expected at most %0d", rise_cnt, push_cnt);
                        end
                    end
                    blen++;
                end else if (busy_prev) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL done_unexpected: got completion expected none");
                    end else begin
                        checks--;
                        e = sb.pop_front();
                        chk({e.tag, "_q"}, q, e.q);
                        chk({e.tag, "_busy_len"}, 32'(blen), 32'(e.len));
                        $display("txn %s q=%h busy_cycles=%0d", e.tag, q, blen);
                        hold = e.q;
                    end
                    blen = 0;
                end else if (reset !== 1'b1) begin
                    chk("q_hold", q, hold);
                end
                busy_prev = (busy === 1'b1);
            end
        end
    end

    // mode 0: drop start at accept, 1: hold start 10 cycles past completion, 2: drop mid-operation
    task automatic do_req(input int off, input logic w, input logic [31:0] d, input int mode, input string tag);
        logic [31:0] e;
        int n;
        @(posedge clk); #1;
        address = BASE + 27'(off);
        data    = d;
        we      = w;
        start   = 1'b1;
        #1;
        chk({tag, "_sel"}, 32'(sel), 32'd1);
        e = predict(off, w, d);
        sb.push_back('{e, WS + 2, tag});
        push_cnt++;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy !== 1'b1 && n < 8);
        if (busy !== 1'b1) begin
            chk({tag, "_accept_timeout"}, 32'(busy), 32'd1);
        end
        address = BASE + 27'($urandom_range(0, TOP));
        data    = $urandom;
        we      = 1'($urandom);
        if (mode == 0) start = 1'b0;
        if (mode == 2) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            start = 1'b0;
        end
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (busy !== 1'b0) begin
            chk({tag, "_done_timeout"}, 32'(busy), 32'd0);
        end
        if (mode == 1) begin
            repeat (10) begin
                @(negedge clk);
                chk({tag, "_no_retrigger"}, 32'(busy), 32'd0);
            end
        end
        start = 1'b0;
    endtask

    task automatic do_miss(input logic [26:0] a, input string tag);
        @(posedge clk); #1;
        address = a;
        data    = $urandom;
        we      = 1'b1;
        start   = 1'b1;
        #1;
        chk({tag, "_sel"}, 32'(sel), 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk({tag, "_busy"}, 32'(busy), 32'd0);
        end
        $display("txn %s addr=%h ignored", tag, a);
        start = 1'b0;
    endtask

    task automatic do_reset_abort(input int off, input logic [31:0] d);
        int n;
        @(posedge clk); #1;
        address = BASE + 27'(off);
        data    = d;
        we      = 1'b1;
        start   = 1'b1;
        sb.push_back('{32'h0, 1, "rst_abort"});
        push_cnt++;
        model_q = '0;
        m_wr    = '0;
        m_rd    = '0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy !== 1'b1 && n < 8);
        reset = 1'b1;
        start = 1'b0;
        @(negedge clk);
        chk("rst_abort_busy", 32'(busy), 32'd0);
        chk("rst_abort_q", q, 32'h0);
        reset = 1'b0;
    endtask

    int pool[$] = '{0, 1, 2, 3, 5, 16, 127, 200, TOP};

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [26:0] ma;
        int r;
        reset   = 1'b1;
        start   = 1'b0;
        we      = 1'b0;
        data    = '0;
        address = BASE;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_q", q, 32'h0);
        reset  = 1'b0;
        mon_en = 1'b1;

        foreach (pool[i]) do_req(pool[i], 1'b1, $urandom, 0, "init_wr");

        do_req(5, 1'b1, 32'hCAFEBABE, 0, "wr5");
        do_req(5, 1'b0, 32'h0, 0, "rd5");
        do_req(1, 1'b0, 32'h0, 1, "rd1_hold");
        do_miss(27'h0000010, "miss10");
        do_req(16, 1'b0, 32'h0, 0, "rd10");
        do_reset_abort(3, 32'h12345678);
        do_req(3, 1'b0, 32'h0, 0, "rd3");
        do_req(TOP, 1'b1, 32'hA5A5_0FF0, 0, "wr_top");
        do_req(TOP, 1'b0, 32'h0, 0, "rd_top");
        do_req(0, 1'b0, 32'h0, 0, "rd0_nowrap");

`ifdef CPU_BUS_RESPONDER_STATS_EN
        do_req(TOP, 1'b1, 32'h0, 0, "stat_clr");
        do_req(1, 1'b1, $urandom, 0, "stat_w1");
        do_req(2, 1'b1, $urandom, 0, "stat_w2");
        do_req(5, 1'b1, $urandom, 0, "stat_w3");
        do_req(1, 1'b0, 32'h0, 0, "stat_r1");
        do_req(2, 1'b0, 32'h0, 0, "stat_r2");
        do_req(TOP, 1'b0, 32'h0, 0, "stat_rd");
        do_req(TOP, 1'b1, 32'h0, 0, "stat_clr2");
        do_req(TOP, 1'b0, 32'h0, 0, "stat_rd0");
`endif

        for (int k = 0; k < 60; k++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                ma = 27'($urandom);
                if (ma[26:AB] == BASE[26:AB]) ma[26] = ~ma[26];
                do_miss(ma, "rnd_miss");
            end else begin
                do_req(pool[$urandom_range(0, pool.size() - 1)], 1'($urandom), $urandom,
                       int'($urandom_range(0, 2)), "rnd");
            end
        end

        repeat (4) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_bus_responder.md
Name: cpu_bus_responder

Overview:
- Responder end of the CPU memory handshake (address/data/we/start → busy/q).
- Implements a memory-mapped scratchpad/mailbox RAM window with a programmable wait-state count.
- Sits beside the memory unit on the same CPU request bus.
- Responds only to addresses inside its window; ignores everything else so other responders can share the bus.

Parameters:
- BASE_ADDR, 27'h0400000, window base address; low ADDR_BITS bits must be zero.
- ADDR_BITS, 8, word-address width of the window; depth is 2^ADDR_BITS 32-bit words.
- WAIT_STATES, 2, extra busy cycles inserted before completion; legal range 0..15.

Ports:
- clk, input, 1, system clock; all logic on rising edge.
- reset, input, 1, synchronous active-high reset.
- address, input, 27, CPU word address.
- data, input, 32, CPU write data.
- we, input, 1, 1 = write, 0 = read; sampled at accept.
- start, input, 1, CPU request strobe (level).
- busy, output, 1, high while an accepted request is in progress.
- q, output, 32, read data; valid from the DONE cycle until the next accept.
- sel, output, 1, combinational: address lies inside the window.

Behaviour:
- Reset: busy=0, q=0, state=IDLE, armed=1. RAM contents are not cleared.
- Window hit: sel = (address[26:ADDR_BITS] == BASE_ADDR[26:ADDR_BITS]).
- Accept condition: state==IDLE && start && sel && armed.
  - On accept, latch address[ADDR_BITS-1:0], data and we.
  - Set armed=0 and cnt=WAIT_STATES.
  - busy goes to 1 on the next cycle.
- States:
  - IDLE: busy=0. Go to WAIT on accept.
  - WAIT: busy=1. If cnt==0, go to ACCESS; else decrement cnt.
  - ACCESS: busy=1. On a write, write the RAM. On a read, read the RAM (synchronous, 1-cycle). Go to DONE.
  - DONE: busy=0. On a read, q=RAM data; on a write, q is unchanged. Go to IDLE.
- Latency: accept edge to busy falling = WAIT_STATES+2 cycles. With WAIT_STATES=0, busy is high for exactly 2 cycles.
- Re-arm: armed is set again only when start==0 is sampled in any state. A start held high after DONE never triggers a second access. The CPU must drop start for at least 1 cycle between requests.
- Non-hit request: no state change, busy stays 0, q is held.
- If address or data change while busy: ignored, because the latched copies are used.
- If start drops mid-operation: the operation still completes; armed is set.
- Reset asserted mid-operation:
  - Returns to IDLE in the next cycle with busy=0 and q=0.
  - A write in ACCESS during the reset cycle is suppressed (reset has priority).
- Address wrap: only the low ADDR_BITS are used, so the top word of the window is 2^ADDR_BITS-1 with no overflow into neighbouring addresses.
- RAM must infer as block RAM: single port, synchronous read, registered output.

Optional Feature:
- Macro: CPU_BUS_RESPONDER_STATS_EN.
- When defined:
  - Adds 16-bit saturating read and write counters, incremented at ACCESS.
  - Window word 2^ADDR_BITS-1 becomes a read-only status word: q = {wr_cnt, rd_cnt}.
  - Writes to that word clear both counters and do not touch the RAM.
  - Counters reset to 0 and saturate at 16'hFFFF.
- When undefined: the top word is ordinary RAM and there are no counters or extra logic.

Decomposition:
- Shared package (cpu_bus_pkg):
  - State enum: IDLE, WAIT, ACCESS, DONE.
  - Bus address width constant (27) and data width constant (32).
  - STATUS_OFFSET constant, defined as all-ones in ADDR_BITS.
- One sub-module, responder_ram: parameterised single-port synchronous RAM (clk, we, addr, d, q). The FSM, counters and decode stay in the top.

Test Plan:
- Write 0xCAFEBABE to BASE_ADDR+5 (WAIT_STATES=2), then read it back → busy high exactly 4 cycles each time; q=0xCAFEBABE in the DONE cycle and held afterwards.
- start held high across completion for 10 cycles on a read of BASE_ADDR+1 → exactly one access; busy never re-asserts until start has been low for 1 cycle.
- Request to address 27'h0000010, outside the window → sel=0, busy stays 0, q unchanged, no RAM write (a later read of BASE_ADDR+0x10 returns the old value).
- Assert reset during the WAIT of a write of 0x12345678 to BASE_ADDR+3 → busy=0 and q=0 the next cycle; a later read of +3 returns its prior contents.
- WAIT_STATES=0 back-to-back: write then read of BASE_ADDR+255 with a 1-cycle start gap → busy is 2 cycles each; read returns the written value; no wrap to BASE_ADDR+0.
- With CPU_BUS_RESPONDER_STATS_EN: 3 writes and 2 reads, then read of the status word → q=0x00030002 (the status read itself counts after sampling); write to the status word then read it → q=0x00000000.
